// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter/sequencer for a single-port synchronous memory.
// One single-beat read or write in flight at a time; all outputs registered.
module mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);
    localparam logic [1:0] IDLE = 2'd0, CMD = 2'd1, RWAIT = 2'd2;
    localparam int CW = $clog2(RD_LAT + 1);

    logic [1:0]        state_q, state_d;
    logic              prio_q, prio_d, owner_q, owner_d, we_q, we_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic              rd_q, rd_d, wr_q, wr_d, busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              win, wsel, start, done;

    always_comb begin
        // prio_q names the requester that wins a tie (the one not granted last)
        win       = (req0 && req1) ? prio_q : req1;
        wsel      = win ? we1 : we0;
        start     = (state_q == IDLE) && (req0 || req1);
        done      = (state_q == RWAIT) && (cnt_q == CW'(1));
        state_d   = start ? CMD
                  : ((state_q == CMD && !we_q) || (state_q == RWAIT && !done)) ? RWAIT : IDLE;
        owner_d   = start ? win : owner_q;
        prio_d    = start ? ~win : prio_q;
        we_d      = start ? wsel : we_q;
        addr_d    = start ? (win ? addr1 : addr0) : addr_q;
        wdata_d   = start ? (win ? wdata1 : wdata0) : wdata_q;
        cnt_d     = (state_q == CMD) ? CW'(RD_LAT) : (state_q == RWAIT) ? cnt_q - CW'(1) : cnt_q;
        gnt0_d    = start && !win;
        gnt1_d    = start && win;
        rd_d      = start && !wsel;
        wr_d      = start && wsel;
        rvalid0_d = done && !owner_q;
        rvalid1_d = done && owner_q;
        rdata0_d  = rvalid0_d ? mem_data_out : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_data_out : rdata1_q;
        busy_d    = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign rvalid0     = rvalid0_q;
    assign rvalid1     = rvalid1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign mem_read    = rd_q;
    assign mem_write   = wr_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus random transactions against a transaction-level reference of
// memory contents, grant order and per-requester read data, with a behavioural memory attached.
module tb_mem_arbiter;
    localparam int RD_LAT = 1;

    logic       clk = 1'b0, rst;
    logic       req0, req1, we0, we1;
    logic [4:0] addr0, addr1, mem_addr;
    logic [7:0] wdata0, wdata1, rdata0, rdata1, mem_data_in, mem_data_out;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write, busy;

    int nchk = 0, nerr = 0, last;
    logic prev_wr;
    logic [7:0] ref_mem [32];
    logic [7:0] exp_rd [2];
    logic [7:0] mem [32];
    logic [7:0] pipe [RD_LAT];

    mem_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_read(mem_read), .mem_write(mem_write), .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: data of a strobed read appears RD_LAT cycles after the strobe edge
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_data_in;
        pipe[0] <= mem_read ? mem[mem_addr] : 8'hEE;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_data_out = pipe[RD_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("strobe_excl", 32'(mem_read & mem_write), 0);
        chk("gnt_excl", 32'(gnt0 & gnt1), 0);
        chk("rvalid_excl", 32'(rvalid0 & rvalid1), 0);
        chk("wr_consec", 32'(prev_wr & mem_write), 0);
        prev_wr = mem_write;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {25'b0, gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write, busy}, 0);
        chk({tag, "_rdata"}, {16'b0, rdata0, rdata1}, 0);
        chk({tag, "_memif"}, {19'b0, mem_addr, mem_data_in}, 0);
    endtask

    task automatic hard_reset(input string tag);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        tick();
        chk_zero(tag);
        rst = 1'b0; last = -1; exp_rd[0] = 8'h00; exp_rd[1] = 8'h00; prev_wr = 1'b0;
        tick();
    endtask

    task automatic drive(input int r, input logic w, input logic [4:0] a, input logic [7:0] d);
        if (r == 1) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    task automatic op(input int r, input logic w, input logic [4:0] a, input logic [7:0] d);
        drive(r, w, a, d);
        tick();
        chk("op_gnt0", 32'(gnt0), 32'(r == 0));
        chk("op_gnt1", 32'(gnt1), 32'(r == 1));
        chk("op_strobes", {30'b0, mem_write, mem_read}, {30'b0, w, !w});
        chk("op_addr", 32'(mem_addr), 32'(a));
        chk("op_busy", 32'(busy), 1);
        if (w) chk("op_wdata", 32'(mem_data_in), 32'(d));
        req0 = 1'b0; req1 = 1'b0; last = r;
        if (w) begin
            ref_mem[a] = d;
            tick();
            chk("wr_end", {28'b0, gnt0, gnt1, busy, mem_write}, 0);
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                tick();
                chk("rwait_ctl", {26'b0, gnt0, gnt1, rvalid0, rvalid1, mem_read, busy}, 1);
                chk("rwait_addr", 32'(mem_addr), 32'(a));
            end
            tick();
            exp_rd[r] = ref_mem[a];
            chk("rd_rvalid0", 32'(rvalid0), 32'(r == 0));
            chk("rd_rvalid1", 32'(rvalid1), 32'(r == 1));
            chk("rd_rdata0", 32'(rdata0), 32'(exp_rd[0]));
            chk("rd_rdata1", 32'(rdata1), 32'(exp_rd[1]));
            chk("rd_busy", 32'(busy), 0);
        end
    endtask

    task automatic tie(input logic [4:0] a0, input logic [7:0] d0, input logic [4:0] a1, input logic [7:0] d1);
        int w;
        logic [4:0] aw, al;
        logic [7:0] dw, dl;
        w = (last == 0) ? 1 : 0;
        aw = w ? a1 : a0; dw = w ? d1 : d0;
        al = w ? a0 : a1; dl = w ? d0 : d1;
        drive(0, 1'b1, a0, d0);
        drive(1, 1'b1, a1, d1);
        tick();
        chk("tie_first", {30'b0, gnt0, gnt1}, (w == 0) ? 2 : 1);
        chk("tie_first_mem", {18'b0, mem_write, mem_read, mem_addr, mem_data_in}, {18'b0, 2'b10, aw, dw});
        if (w == 1) req1 = 1'b0; else req0 = 1'b0;
        ref_mem[aw] = dw; last = w;
        tick();
        chk("tie_gap", {29'b0, gnt0, gnt1, busy}, 0);
        tick();
        chk("tie_second", {30'b0, gnt0, gnt1}, (w == 0) ? 1 : 2);
        chk("tie_second_mem", {18'b0, mem_write, mem_read, mem_addr, mem_data_in}, {18'b0, 2'b10, al, dl});
        req0 = 1'b0; req1 = 1'b0;
        ref_mem[al] = dl; last = 1 - w;
        tick();
        chk("tie_idle", 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; prev_wr = 1'b0;
        hard_reset("reset");
        for (int i = 0; i < 32; i++) op(0, 1'b1, 5'(i), 8'h00);
        for (int i = 0; i < 32; i++) op(0, 1'b0, 5'(i), 8'h00);
        for (int i = 0; i < 32; i++) op(1, 1'b1, 5'(i), 8'(i));
        for (int i = 0; i < 32; i++) op(1, 1'b0, 5'(i), 8'h00);
        hard_reset("reset2");
        for (int i = 0; i < 4; i++) tie(5'd3, 8'h33, 5'd4, 8'h44);
        op(0, 1'b0, 5'd3, 8'h00);
        op(1, 1'b0, 5'd4, 8'h00);
        op(0, 1'b1, 5'd5, 8'hA5);
        op(0, 1'b0, 5'd5, 8'h00);
        // Abort a read while the arbiter waits on the memory
        drive(0, 1'b0, 5'd5, 8'h00);
        tick();
        chk("mid_gnt", {30'b0, gnt0, mem_read}, 3);
        req0 = 1'b0;
        tick();
        chk("mid_rwait", {30'b0, busy, rvalid0}, 2);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00; last = -1;
        tick();
        chk_zero("rst_hold");
        #3 rst = 1'b0; prev_wr = 1'b0;
        tie(5'd7, 8'h5A, 5'd8, 8'h11);
        op(0, 1'b0, 5'd7, 8'h00);
        op(1, 1'b0, 5'd8, 8'h00);
        for (int i = 0; i < 8; i++) op(1, 1'b1, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                tie(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)),
                    5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
            else
                op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 32; i++) op(i % 2, 1'b0, 5'(i), 8'h00);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter and sequencer for the 32 x 8 synchronous memory. Sits between two bus masters (testbench drivers or RTL clients) and the memory's addr/data_in/data_out/read/write port. Accepts one single-beat read or write at a time, drives the memory strobes for exactly one cycle, and returns read data to the owning requester with a one-cycle valid pulse.

## Interface
- ADDR_W, 5, memory address width (32 locations)
- DATA_W, 8, memory data width
- RD_LAT, 1, memory read latency in cycles (data_out valid RD_LAT cycles after read strobe edge); legal 1..4

- clk  input  1  single clock, all logic on posedge
- rst  input  1  asynchronous, active-high reset
- req0 / req1  input  1  request from requester n; held stable until gntn
- we0 / we1  input  1  1 = write, 0 = read; qualified by reqn
- addr0 / addr1  input  ADDR_W  request address
- wdata0 / wdata1  input  DATA_W  write data
- gnt0 / gnt1  output  1  one-cycle pulse: request accepted and latched
- rvalid0 / rvalid1  output  1  one-cycle pulse: rdatan holds read result
- rdata0 / rdata1  output  DATA_W  read data, held until next read for that requester
- mem_addr  output  ADDR_W  memory address
- mem_data_in  output  DATA_W  memory write data
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_data_out  input  DATA_W  memory read data
- busy  output  1  high whenever state != IDLE

## Operation
- All outputs registered. Reset values: gnt*, rvalid*, mem_read, mem_write, busy = 0; rdata*, mem_addr, mem_data_in = 0; state = IDLE; priority pointer = requester 0.
- States: IDLE, CMD, RWAIT.
- IDLE: on clock edge with any reqn high, select winner; latch its we/addr/wdata; pulse gntn; assert mem_write (we=1) or mem_read (we=0) with latched addr/data; go CMD. No request: stay IDLE, strobes 0.
- Arbitration: only one requesting -> it wins. Both requesting -> requester not granted most recently wins. Pointer updates on every grant. From reset, req0 wins a tie.
- CMD: strobes high for this one cycle only. Write -> IDLE. Read -> RWAIT, load wait counter with RD_LAT.
- RWAIT: decrement counter each edge; on final edge capture mem_data_out into rdata of owner, pulse its rvalid, go IDLE. mem_addr held stable through RWAIT.
- mem_read and mem_write never both high. At most one gnt and one rvalid high per cycle.
- Requester must deassert reqn by the edge ending its gnt cycle; a req still high in IDLE afterwards is a new request.
- rdata of the non-owning requester is never modified.
- Async rst at any point (including CMD or RWAIT): transaction abandoned, no gnt/rvalid issued for it, all outputs to reset values immediately; next request after rst release is served normally.

## Timing
- Edge k: IDLE samples reqn. Cycle k+1: gntn = 1, strobe = 1, busy = 1.
- Write: memory writes at edge k+1; IDLE in cycle k+2; next request sampled at edge k+2. Write throughput 1 per 2 cycles.
- Read: rvalidn and rdatan valid in cycle k+2+RD_LAT (k+3 for RD_LAT=1); IDLE same cycle. Read throughput 1 per 2+RD_LAT cycles.
- busy high from cycle k+1 through last cycle before IDLE (mem_addr stable over the same span).
- Requests arriving while busy are held pending, not dropped; sampled in the next IDLE cycle.

## Test plan
- Clear: req0 writes 0x00 to addr 0..31, then reads 0..31 -> every rvalid0 returns 0x00; rvalid1 never pulses.
- Data = address: req1 writes addr i = i for 0..31, reads back -> rdata1 == i each time; gnt1 one cycle after each sampled req1.
- Tie from reset: req0 and req1 both high (writes to 3 = 0x33 and 4 = 0x44), held until granted -> gnt0 first, gnt1 two cycles later; four repeated tied rounds alternate 0,1,0,1,…; readback 0x33/0x44.
- Read latency: write addr 5 = 0xA5, then read 5 via req0 sampled at edge k -> mem_read high in cycle k+1 only, rvalid0 = 1 with rdata0 = 0xA5 in cycle k+3 (RD_LAT=1), rdata1 unchanged.
- Reset mid-read: assert rst during RWAIT -> all outputs 0 at once, no rvalid pulse; after release, write addr 7 = 0x5A and read -> 0x5A returned normally, req0 wins first tie.
- Back-to-back single requester: req1 issues 8 consecutive writes -> gnt1 every 2 cycles, mem_write never high on two consecutive cycles, busy toggles accordingly.
